// File: rtl/multi_stream_prefetch_ctrl_if.sv
// Demand-training snoop, prefetch request and prefetch-retire signals of the
// multi-stream prefetch controller.
interface multi_stream_prefetch_ctrl_if #(
  parameter int unsigned ADDR_BITS       = 64,
  parameter int unsigned STREAM_IDX_W    = 2,
  parameter int unsigned BURST_LEN_WIDTH = 8,
  parameter int unsigned TID_WIDTH       = 8
) ();
  logic                       train_valid;
  logic [ADDR_BITS-1:0]       train_addr;
  logic [BURST_LEN_WIDTH-1:0] train_len;
  logic [TID_WIDTH-1:0]       train_id;
  logic                       train_drop;
  logic                       pf_valid;
  logic                       pf_ready;
  logic [ADDR_BITS-1:0]       pf_addr;
  logic [BURST_LEN_WIDTH-1:0] pf_len;
  logic [TID_WIDTH-1:0]       pf_id;
  logic [STREAM_IDX_W-1:0]    pf_stream;
  logic                       done_valid;
  logic [STREAM_IDX_W-1:0]    done_stream;

  modport master (
    output train_valid, train_addr, train_len, train_id, pf_ready, done_valid, done_stream,
    input  train_drop, pf_valid, pf_addr, pf_len, pf_id, pf_stream
  );

  modport slave (
    input  train_valid, train_addr, train_len, train_id, pf_ready, done_valid, done_stream,
    output train_drop, pf_valid, pf_addr, pf_len, pf_id, pf_stream
  );
endinterface

// File: rtl/multi_stream_prefetch_ctrl.sv
// Multi-stream stride prefetch controller: per-ARID stride/confidence training and
// round-robin prefetch issue among confident streams.
module multi_stream_prefetch_ctrl #(
  parameter int unsigned ADDR_BITS       = 64,
  parameter int unsigned NUM_STREAMS     = 4,
  parameter int unsigned STREAM_IDX_W    = 2,
  parameter int unsigned BURST_LEN_WIDTH = 8,
  parameter int unsigned TID_WIDTH       = 8,
  parameter int unsigned CONF_WIDTH      = 3,
  parameter int unsigned OUTST_WIDTH     = 5,
  parameter int unsigned THROTTLE_WIDTH  = 6,
  parameter int unsigned WATCHDOG_WIDTH  = 10
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          en,
  input  logic                          flush,
  multi_stream_prefetch_ctrl_if.slave   bus,
  output logic [NUM_STREAMS-1:0]        stream_active,
  input  logic [ADDR_BITS-1:0]          crs_bar,
  input  logic [ADDR_BITS-1:0]          crs_limit,
  input  logic [OUTST_WIDTH-1:0]        crs_outstandingLimit,
  input  logic [CONF_WIDTH-1:0]         crs_confThreshold,
  input  logic [THROTTLE_WIDTH-1:0]     crs_throttle,
  input  logic [WATCHDOG_WIDTH-1:0]     crs_watchdogLimit
);
  typedef enum logic [1:0] {StFree, StArm, StTrain, StActive} st_e;
  typedef logic [STREAM_IDX_W-1:0] idx_t;

  localparam idx_t                      IdxOne   = idx_t'(1);
  localparam logic [OUTST_WIDTH-1:0]    OutstOne = OUTST_WIDTH'(1);
  localparam logic [CONF_WIDTH-1:0]     ConfOne  = CONF_WIDTH'(1);
  localparam logic [THROTTLE_WIDTH-1:0] ThrOne   = THROTTLE_WIDTH'(1);
  localparam logic [WATCHDOG_WIDTH-1:0] IdleOne  = WATCHDOG_WIDTH'(1);

  st_e                        st_q     [NUM_STREAMS], st_d     [NUM_STREAMS];
  logic [TID_WIDTH-1:0]       id_q     [NUM_STREAMS], id_d     [NUM_STREAMS];
  logic [BURST_LEN_WIDTH-1:0] len_q    [NUM_STREAMS], len_d    [NUM_STREAMS];
  logic [ADDR_BITS-1:0]       last_q   [NUM_STREAMS], last_d   [NUM_STREAMS];
  logic [ADDR_BITS-1:0]       stride_q [NUM_STREAMS], stride_d [NUM_STREAMS];
  logic [ADDR_BITS-1:0]       nxt_q    [NUM_STREAMS], nxt_d    [NUM_STREAMS];
  logic [CONF_WIDTH-1:0]      conf_q   [NUM_STREAMS], conf_d   [NUM_STREAMS];
  logic [OUTST_WIDTH-1:0]     outst_q  [NUM_STREAMS], outst_d  [NUM_STREAMS];
  logic [WATCHDOG_WIDTH-1:0]  idle_q   [NUM_STREAMS], idle_d   [NUM_STREAMS];

  logic                       pf_valid_q, pf_valid_d;
  logic [ADDR_BITS-1:0]       pf_addr_q, pf_addr_d;
  logic [BURST_LEN_WIDTH-1:0] pf_len_q, pf_len_d;
  logic [TID_WIDTH-1:0]       pf_id_q, pf_id_d;
  idx_t                       pf_stream_q, pf_stream_d;
  idx_t                       rr_q, rr_d, victim_q, victim_d;
  logic [THROTTLE_WIDTH-1:0]  thr_q, thr_d;
  logic                       drop_q, drop_d;

  logic hit, free_found, vic_found, iss_found, hs, reinit;
  idx_t hit_idx, free_idx, vic_idx, iss_idx, tgt;
  logic [NUM_STREAMS-1:0] elig;
  logic [ADDR_BITS-1:0]   s;
  logic [CONF_WIDTH-1:0]  conf_nx;

  always_comb begin
    hit = 1'b0;  hit_idx  = '0;
    free_found = 1'b0; free_idx = '0;
    vic_found = 1'b0;  vic_idx  = '0;
    iss_found = 1'b0;  iss_idx  = '0;
    elig = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (st_q[i] != StFree && id_q[i] == bus.train_id && !hit) begin
        hit = 1'b1;
        hit_idx = idx_t'(i);
      end
      if (st_q[i] == StFree && outst_q[i] == '0 && !free_found) begin
        free_found = 1'b1;
        free_idx = idx_t'(i);
      end
      elig[i] = (st_q[i] == StActive) && (outst_q[i] < crs_outstandingLimit) &&
                (nxt_q[i] >= crs_bar) && (nxt_q[i] <= crs_limit);
    end
    // Both searches are circular, starting at their respective pointers.
    for (int k = 0; k < NUM_STREAMS; k++) begin
      if (outst_q[victim_q + idx_t'(k)] == '0 && !vic_found) begin
        vic_found = 1'b1;
        vic_idx = victim_q + idx_t'(k);
      end
      if (elig[rr_q + idx_t'(k)] && !iss_found) begin
        iss_found = 1'b1;
        iss_idx = rr_q + idx_t'(k);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_STREAMS; i++) begin
      st_d[i]     = st_q[i];
      id_d[i]     = id_q[i];
      len_d[i]    = len_q[i];
      last_d[i]   = last_q[i];
      stride_d[i] = stride_q[i];
      nxt_d[i]    = nxt_q[i];
      conf_d[i]   = conf_q[i];
      outst_d[i]  = outst_q[i];
      idle_d[i]   = idle_q[i];
    end
    pf_valid_d  = pf_valid_q;
    pf_addr_d   = pf_addr_q;
    pf_len_d    = pf_len_q;
    pf_id_d     = pf_id_q;
    pf_stream_d = pf_stream_q;
    rr_d        = rr_q;
    victim_d    = victim_q;
    thr_d       = thr_q;
    drop_d      = 1'b0;
    hs          = pf_valid_q && bus.pf_ready;
    tgt         = hit ? hit_idx : (free_found ? free_idx : vic_idx);
    reinit      = !hit || (bus.train_len != len_q[tgt]);
    s           = bus.train_addr - last_q[tgt];
    conf_nx     = (conf_q[tgt] == '1) ? conf_q[tgt] : conf_q[tgt] + ConfOne;

    // A handshake on a pending request completes even while disabled.
    if (hs) begin
      pf_valid_d = 1'b0;
      rr_d = pf_stream_q + IdxOne;
      thr_d = crs_throttle;
      nxt_d[pf_stream_q] = nxt_q[pf_stream_q] + stride_q[pf_stream_q];
    end else if (en && thr_q != '0) begin
      thr_d = thr_q - ThrOne;
    end

    if (en && !flush && !pf_valid_q && thr_q == '0 && iss_found) begin
      pf_valid_d  = 1'b1;
      pf_addr_d   = nxt_q[iss_idx];
      pf_len_d    = len_q[iss_idx];
      pf_id_d     = id_q[iss_idx];
      pf_stream_d = iss_idx;
    end

    for (int i = 0; i < NUM_STREAMS; i++) begin
      logic inc, dec;
      inc = hs && (pf_stream_q == idx_t'(i));
      dec = en && bus.done_valid && (bus.done_stream == idx_t'(i));
      if (inc && !dec) begin
        outst_d[i] = outst_q[i] + OutstOne;
      end else if (dec && !inc && outst_q[i] != '0) begin
        outst_d[i] = outst_q[i] - OutstOne;
      end
    end

    if (en && flush) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        st_d[i]   = StFree;
        idle_d[i] = '0;
      end
    end else if (en) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        if (st_q[i] != StFree) begin
          if (crs_watchdogLimit != '0 && idle_q[i] == crs_watchdogLimit) begin
            st_d[i]   = StFree;
            idle_d[i] = '0;
          end else if (idle_q[i] != '1) begin
            idle_d[i] = idle_q[i] + IdleOne;
          end
        end
      end
      if (bus.train_valid) begin
        if (!hit && !free_found && !vic_found) begin
          drop_d = 1'b1;
        end else if (reinit) begin
          if (!hit && !free_found) victim_d = vic_idx + IdxOne;
          st_d[tgt]     = StArm;
          id_d[tgt]     = bus.train_id;
          len_d[tgt]    = bus.train_len;
          last_d[tgt]   = bus.train_addr;
          stride_d[tgt] = '0;
          conf_d[tgt]   = '0;
          idle_d[tgt]   = '0;
        end else begin
          // A hit overrides a watchdog expiry in the same cycle.
          st_d[tgt]   = st_q[tgt];
          idle_d[tgt] = '0;
          last_d[tgt] = bus.train_addr;
          if (s == '0) begin
            st_d[tgt] = st_q[tgt];
          end else if (st_q[tgt] == StArm || s != stride_q[tgt]) begin
            st_d[tgt]     = StTrain;
            stride_d[tgt] = s;
            conf_d[tgt]   = '0;
          end else begin
            conf_d[tgt] = conf_nx;
            if (st_q[tgt] == StTrain && conf_nx >= crs_confThreshold) begin
              st_d[tgt]  = StActive;
              nxt_d[tgt] = bus.train_addr + stride_q[tgt];
            end else if (st_q[tgt] == StActive && nxt_q[tgt] == bus.train_addr) begin
              nxt_d[tgt] = bus.train_addr + stride_q[tgt];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        st_q[i]     <= StFree;
        id_q[i]     <= '0;
        len_q[i]    <= '0;
        last_q[i]   <= '0;
        stride_q[i] <= '0;
        nxt_q[i]    <= '0;
        conf_q[i]   <= '0;
        outst_q[i]  <= '0;
        idle_q[i]   <= '0;
      end
      pf_valid_q  <= 1'b0;
      pf_addr_q   <= '0;
      pf_len_q    <= '0;
      pf_id_q     <= '0;
      pf_stream_q <= '0;
      rr_q        <= '0;
      victim_q    <= '0;
      thr_q       <= '0;
      drop_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        st_q[i]     <= st_d[i];
        id_q[i]     <= id_d[i];
        len_q[i]    <= len_d[i];
        last_q[i]   <= last_d[i];
        stride_q[i] <= stride_d[i];
        nxt_q[i]    <= nxt_d[i];
        conf_q[i]   <= conf_d[i];
        outst_q[i]  <= outst_d[i];
        idle_q[i]   <= idle_d[i];
      end
      pf_valid_q  <= pf_valid_d;
      pf_addr_q   <= pf_addr_d;
      pf_len_q    <= pf_len_d;
      pf_id_q     <= pf_id_d;
      pf_stream_q <= pf_stream_d;
      rr_q        <= rr_d;
      victim_q    <= victim_d;
      thr_q       <= thr_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_STREAMS; i++) stream_active[i] = (st_q[i] == StActive);
  end

  assign bus.train_drop = drop_q;
  assign bus.pf_valid   = pf_valid_q;
  assign bus.pf_addr    = pf_addr_q;
  assign bus.pf_len     = pf_len_q;
  assign bus.pf_id      = pf_id_q;
  assign bus.pf_stream  = pf_stream_q;
endmodule

// File: tb/tb_multi_stream_prefetch_ctrl.sv
// Self-checking bench for multi_stream_prefetch_ctrl: table-driven training vectors,
// a prefetch scoreboard, and hand-written multi-cycle corner sequences.
module tb_multi_stream_prefetch_ctrl;
  logic        clk = 1'b0;
  logic        resetN, en, flush;
  logic [3:0]  stream_active;
  logic [63:0] crs_bar, crs_limit;
  logic [4:0]  crs_outstandingLimit;
  logic [2:0]  crs_confThreshold;
  logic [5:0]  crs_throttle;
  logic [9:0]  crs_watchdogLimit;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [7:0]  id;
    logic [1:0]  stream;
  } pf_t;
  pf_t exp_q[$];

  typedef struct {
    logic [7:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [3:0]  exp_active;
    logic        exp_drop;
  } vec_t;
  vec_t vecs[4];

  multi_stream_prefetch_ctrl_if #(
    .ADDR_BITS(64), .STREAM_IDX_W(2), .BURST_LEN_WIDTH(8), .TID_WIDTH(8)
  ) bus ();

  multi_stream_prefetch_ctrl dut (
    .clk                  (clk),
    .resetN               (resetN),
    .en                   (en),
    .flush                (flush),
    .bus                  (bus),
    .stream_active        (stream_active),
    .crs_bar              (crs_bar),
    .crs_limit            (crs_limit),
    .crs_outstandingLimit (crs_outstandingLimit),
    .crs_confThreshold    (crs_confThreshold),
    .crs_throttle         (crs_throttle),
    .crs_watchdogLimit    (crs_watchdogLimit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every handshake must match the oldest expected prefetch.
  always @(negedge clk) begin : mon
    pf_t e;
    if (resetN && bus.pf_valid && bus.pf_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pf: got addr %0h stream %0d expected no request",
                 bus.pf_addr, bus.pf_stream);
      end else begin
        e = exp_q.pop_front();
        check("pf_addr", bus.pf_addr, e.addr);
        check("pf_len", bus.pf_len, e.len);
        check("pf_id", bus.pf_id, e.id);
        check("pf_stream", bus.pf_stream, e.stream);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] a, input logic [7:0] l, input logic [7:0] id,
                          input logic [1:0] st);
    exp_q.push_back('{addr: a, len: l, id: id, stream: st});
  endtask

  task automatic do_train(input logic [7:0] id, input logic [63:0] a, input logic [7:0] l);
    @(posedge clk);
    #1;
    bus.train_valid = 1'b1;
    bus.train_id    = id;
    bus.train_addr  = a;
    bus.train_len   = l;
    @(posedge clk);
    #1;
    bus.train_valid = 1'b0;
  endtask

  task automatic do_done(input logic [1:0] st);
    @(posedge clk);
    #1;
    bus.done_valid  = 1'b1;
    bus.done_stream = st;
    @(posedge clk);
    #1;
    bus.done_valid  = 1'b0;
  endtask

  task automatic do_flush();
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d prefetches outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    resetN = 1'b0; en = 1'b1; flush = 1'b0;
    bus.train_valid = 1'b0; bus.train_addr = '0; bus.train_len = '0; bus.train_id = '0;
    bus.pf_ready = 1'b0; bus.done_valid = 1'b0; bus.done_stream = '0;
    crs_bar = '0; crs_limit = '1; crs_outstandingLimit = 5'd2; crs_confThreshold = 3'd2;
    crs_throttle = '0; crs_watchdogLimit = '0;

    vecs[0] = '{8'd3, 64'h1000, 8'd3, 4'b0000, 1'b0};
    vecs[1] = '{8'd3, 64'h1100, 8'd3, 4'b0000, 1'b0};
    vecs[2] = '{8'd3, 64'h1200, 8'd3, 4'b0000, 1'b0};
    vecs[3] = '{8'd3, 64'h1300, 8'd3, 4'b0001, 1'b0};

    tick(2);
    check("rst_pf_valid", bus.pf_valid, 0);
    check("rst_pf_addr", bus.pf_addr, 0);
    check("rst_train_drop", bus.train_drop, 0);
    check("rst_stream_active", stream_active, 0);
    resetN = 1'b1;
    tick(1);

    // Training to ACTIVE on ID 3 with threshold 2
    for (int i = 0; i < 4; i++) begin
      do_train(vecs[i].id, vecs[i].addr, vecs[i].len);
      check("vec_active", stream_active, vecs[i].exp_active);
      check("vec_drop", bus.train_drop, vecs[i].exp_drop);
    end
    tick(2);
    check("first_pf_valid", bus.pf_valid, 1);
    check("first_pf_addr", bus.pf_addr, 64'h1400);
    check("first_pf_len", bus.pf_len, 3);
    check("first_pf_id", bus.pf_id, 3);

    // Outstanding limit 2, then one retire frees a slot
    push_exp(64'h1400, 8'd3, 8'd3, 2'd0);
    push_exp(64'h1500, 8'd3, 8'd3, 2'd0);
    bus.pf_ready = 1'b1;
    wait_empty("limit_two");
    tick(8);
    check("limit_hold_pf_valid", bus.pf_valid, 0);
    push_exp(64'h1600, 8'd3, 8'd3, 2'd0);
    do_done(2'd0);
    wait_empty("after_done");
    tick(4);
    check("after_done_idle", bus.pf_valid, 0);

    // Stride change on ACTIVE stream with a pending request
    bus.pf_ready = 1'b0;
    crs_outstandingLimit = 5'd3;
    tick(3);
    check("pend_pf_valid", bus.pf_valid, 1);
    check("pend_pf_addr", bus.pf_addr, 64'h1700);
    do_train(8'd3, 64'h1500, 8'd3);
    check("retrain_active", stream_active, 4'b0000);
    tick(3);
    check("retrain_hold_valid", bus.pf_valid, 1);
    check("retrain_hold_addr", bus.pf_addr, 64'h1700);
    push_exp(64'h1700, 8'd3, 8'd3, 2'd0);
    bus.pf_ready = 1'b1;
    wait_empty("retrain_release");
    tick(4);
    check("retrain_no_pf", bus.pf_valid, 0);
    do_train(8'd3, 64'h1700, 8'd3);
    check("retrain_conf1", stream_active, 4'b0000);
    crs_outstandingLimit = 5'd4;
    push_exp(64'h1B00, 8'd3, 8'd3, 2'd0);
    do_train(8'd3, 64'h1900, 8'd3);
    check("retrain_conf2", stream_active, 4'b0001);
    wait_empty("retrain_pf");

    // Two streams, round-robin alternation
    bus.pf_ready = 1'b0;
    for (int k = 0; k < 4; k++) do_train(8'd1, 64'h2000 + 64'(k) * 64'h40, 8'd1);
    for (int k = 0; k < 4; k++) do_train(8'd2, 64'h9000 - 64'(k) * 64'h80, 8'd2);
    check("rr_active", stream_active, 4'b0111);
    for (int k = 0; k < 4; k++) begin
      push_exp(64'h2100 + 64'(k) * 64'h40, 8'd1, 8'd1, 2'd1);
      push_exp(64'h8E00 - 64'(k) * 64'h80, 8'd2, 8'd2, 2'd2);
    end
    bus.pf_ready = 1'b1;
    wait_empty("rr_alternate");
    tick(4);
    check("rr_saturated", bus.pf_valid, 0);

    // Fourth busy stream, then a fifth ID is dropped
    for (int k = 0; k < 4; k++) push_exp(64'h3040 + 64'(k) * 64'h10, 8'd4, 8'd4, 2'd3);
    for (int k = 0; k < 4; k++) do_train(8'd4, 64'h3000 + 64'(k) * 64'h10, 8'd4);
    wait_empty("fourth_stream");
    check("all_active", stream_active, 4'b1111);
    do_train(8'd5, 64'h6000, 8'd1);
    check("drop_pulse", bus.train_drop, 1);
    tick(1);
    check("drop_clear", bus.train_drop, 0);
    check("drop_no_alloc", stream_active, 4'b1111);

    // Drain, flush, then the fifth ID lands in entry 0
    crs_outstandingLimit = 5'd0;
    for (int st = 0; st < 4; st++) begin
      for (int k = 0; k < 4; k++) do_done(2'(st));
    end
    do_flush();
    check("flush_active", stream_active, 4'b0000);
    crs_outstandingLimit = 5'd1;
    push_exp(64'h7400, 8'd2, 8'd5, 2'd0);
    for (int k = 0; k < 4; k++) do_train(8'd5, 64'h7000 + 64'(k) * 64'h100, 8'd2);
    wait_empty("realloc_entry0");
    check("realloc_active", stream_active, 4'b0001);
    crs_outstandingLimit = 5'd0;
    do_done(2'd0);
    do_flush();

    // Window excludes next_pf, then the watchdog frees the entry
    crs_outstandingLimit = 5'd4;
    crs_limit = 64'h4FFF;
    crs_watchdogLimit = 10'd8;
    for (int k = 0; k < 4; k++) do_train(8'd6, 64'h5000 + 64'(k) * 64'h100, 8'd1);
    check("wd_active", stream_active, 4'b0001);
    tick(4);
    check("window_no_pf", bus.pf_valid, 0);
    check("wd_still_active", stream_active, 4'b0001);
    tick(10);
    check("wd_freed", stream_active, 4'b0000);
    check("window_end_no_pf", bus.pf_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
